// File: rtl/cpu_checker_fsm.sv
// Trace-line recogniser: consumes one ASCII character per clock and flags
// well-formed register-write ('$') and memory-write ('*') records.
module cpu_checker_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char,
   output logic [1:0] format_type
);

   typedef enum logic [3:0] {
      IDLE,
      TIME,
      AT_SEEN,
      PC,
      COLON,
      SP1,
      REG,
      ADDR,
      SP2,
      LT,
      EQ,
      DATA,
      DONE_REG,
      DONE_MEM
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [2:0] cnt;
   logic [2:0] cnt_nx;
   logic       mem_path;
   logic       mem_path_nx;

   logic is_dec;
   logic is_hex;
   logic is_sp;

   assign is_dec = (char >= "0") && (char <= "9");
   assign is_hex = is_dec || ((char >= "a") && (char <= "f"));
   assign is_sp  = (char == " ");

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         mem_path <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         mem_path <= mem_path_nx;
      end
   end

   // TIME/REG count digits seen; PC/DATA hold digits-1 so eight fit in 3 bits;
   // ADDR hands off to SP2 on its eighth digit for the same reason.
   always_comb begin
      state_nx    = IDLE;
      cnt_nx      = 3'd0;
      mem_path_nx = mem_path;
      if (char == "^") begin
         state_nx = TIME;
      end else begin
         case (state)
            TIME: begin
               if (is_dec && (cnt != 3'd4)) begin
                  state_nx = TIME;
                  cnt_nx   = cnt + 3'd1;
               end else if ((char == "@") && (cnt != 3'd0)) begin
                  state_nx = AT_SEEN;
               end
            end
            AT_SEEN: begin
               if (is_hex) state_nx = PC;
            end
            PC: begin
               if (is_hex && (cnt != 3'd7)) begin
                  state_nx = PC;
                  cnt_nx   = cnt + 3'd1;
               end else if ((char == ":") && (cnt == 3'd7)) begin
                  state_nx = COLON;
               end
            end
            COLON, SP1: begin
               if (is_sp) begin
                  state_nx = SP1;
               end else if (char == "$") begin
                  state_nx    = REG;
                  mem_path_nx = 1'b0;
               end else if (char == "*") begin
                  state_nx    = ADDR;
                  mem_path_nx = 1'b1;
               end
            end
            REG: begin
               if (is_dec && (cnt != 3'd4)) begin
                  state_nx = REG;
                  cnt_nx   = cnt + 3'd1;
               end else if (is_sp && (cnt != 3'd0)) begin
                  state_nx = SP2;
               end else if ((char == "<") && (cnt != 3'd0)) begin
                  state_nx = LT;
               end
            end
            ADDR: begin
               if (is_hex) begin
                  if (cnt == 3'd7) begin
                     state_nx = SP2;
                  end else begin
                     state_nx = ADDR;
                     cnt_nx   = cnt + 3'd1;
                  end
               end
            end
            SP2: begin
               if (is_sp) state_nx = SP2;
               else if (char == "<") state_nx = LT;
            end
            LT: begin
               if (char == "=") state_nx = EQ;
            end
            EQ: begin
               if (is_sp) state_nx = EQ;
               else if (is_hex) state_nx = DATA;
            end
            DATA: begin
               if (is_hex && (cnt != 3'd7)) begin
                  state_nx = DATA;
                  cnt_nx   = cnt + 3'd1;
               end else if ((char == "#") && (cnt == 3'd7)) begin
                  state_nx = mem_path ? DONE_MEM : DONE_REG;
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      case (state)
         DONE_REG: format_type = 2'd1;
         DONE_MEM: format_type = 2'd2;
         default:  format_type = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_cpu_checker_fsm.sv
// Bench for cpu_checker_fsm: directed and random character streams checked
// against a string-level grammar matcher, plus per-test pulse scoreboards.
module tb_cpu_checker_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] char;
   logic [1:0] format_type;

   int total = 0;
   int bad   = 0;

   string      mbuf;
   bit         mhave = 1'b0;
   logic [1:0] exp_q[$];
   logic [1:0] obs_q[$];

   always #5 clk = ~clk;

   cpu_checker_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .char        (char),
      .format_type (format_type)
   );

   function automatic logic [7:0] at(string s, int i);
      if (i < s.len()) return s[i];
      return 8'h00;
   endfunction

   function automatic bit is_dec(logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   function automatic bit is_hex(logic [7:0] c);
      return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
   endfunction

   function automatic int run_len(string s, int i, bit hexd);
      int n = 0;
      while (hexd ? is_hex(at(s, i + n)) : is_dec(at(s, i + n))) n++;
      return n;
   endfunction

   function automatic int sp_len(string s, int i);
      int n = 0;
      while (at(s, i + n) == 8'h20) n++;
      return n;
   endfunction

   // Whole-record grammar check on a buffer running from '^' to '#'.
   function automatic logic [1:0] match_rec(string s);
      int i;
      int n;
      logic [1:0] typ;
      if (at(s, 0) != "^") return 2'd0;
      i = 1;
      n = run_len(s, i, 1'b0);
      if (n < 1 || n > 4) return 2'd0;
      i += n;
      if (at(s, i) != "@") return 2'd0;
      i++;
      n = run_len(s, i, 1'b1);
      if (n != 8) return 2'd0;
      i += n;
      if (at(s, i) != ":") return 2'd0;
      i++;
      i += sp_len(s, i);
      if (at(s, i) == "$") begin
         typ = 2'd1;
         i++;
         n = run_len(s, i, 1'b0);
         if (n < 1 || n > 4) return 2'd0;
      end else if (at(s, i) == "*") begin
         typ = 2'd2;
         i++;
         n = run_len(s, i, 1'b1);
         if (n != 8) return 2'd0;
      end else begin
         return 2'd0;
      end
      i += n;
      i += sp_len(s, i);
      if (at(s, i) != "<" || at(s, i + 1) != "=") return 2'd0;
      i += 2;
      i += sp_len(s, i);
      n = run_len(s, i, 1'b1);
      if (n != 8) return 2'd0;
      i += n;
      if (at(s, i) != "#" || i != s.len() - 1) return 2'd0;
      return typ;
   endfunction

   function automatic logic [1:0] model_step(logic [7:0] c);
      logic [1:0] r = 2'd0;
      if (c == "^") begin
         mbuf  = "^";
         mhave = 1'b1;
      end else if (mhave) begin
         mbuf = $sformatf("%s%c", mbuf, c);
         if (c == "#") begin
            r     = match_rec(mbuf);
            mhave = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic int seq_sig(logic [1:0] q[$]);
      int sig = 1;
      foreach (q[k]) sig = sig * 4 + int'(q[k]);
      return sig;
   endfunction

   task automatic drive_char(input logic [7:0] c, output logic [1:0] obs, output logic [1:0] exp);
      @(negedge clk);
      char = c;
      @(posedge clk);
      #1;
      obs = format_type;
      exp = model_step(c);
   endtask

   function automatic string rand_digits(int n, bit hexd, bit upper);
      string r = "";
      int v;
      logic [7:0] ch;
      for (int k = 0; k < n; k++) begin
         v = hexd ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
         if (v < 10) ch = 8'h30 + 8'(v);
         else ch = (upper ? 8'h41 : 8'h61) + 8'(v - 10);
         r = $sformatf("%s%c", r, ch);
      end
      return r;
   endfunction

   function automatic string spaces(int n);
      string r = "";
      for (int k = 0; k < n; k++) r = {r, " "};
      return r;
   endfunction

   function automatic int rand_len8();
      int r = int'($urandom_range(0, 11));
      return (r == 0) ? 7 : ((r == 1) ? 9 : 8);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      char  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (format_type !== 2'd0) begin
         bad++;
         $display("FAIL reset_state format_type=%0d expected=0", format_type);
      end
      @(negedge clk);
      reset = 1'b1;
      mhave = 1'b0;
   endtask

   task automatic test_reg_record();
      string s = "^1024@000030fc: $2 <= 89abcdef# ";
      logic [1:0] obs, exp;
      obs_q.delete();
      exp_q = '{2'd1};
      for (int k = 0; k < s.len(); k++) begin
         drive_char(s[k], obs, exp);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL reg_record idx=%0d char=%c format_type=%0d expected=%0d", k, s[k], obs, exp);
         end
         if (obs != 2'd0) obs_q.push_back(obs);
      end
      total++;
      if (seq_sig(obs_q) != seq_sig(exp_q)) begin
         bad++;
         $display("FAIL reg_pulses pulses=%0d sig=%0d expected pulses=%0d sig=%0d",
                  obs_q.size(), seq_sig(obs_q), exp_q.size(), seq_sig(exp_q));
      end
   endtask

   task automatic test_mem_record();
      string s = "^7@0000abcd:*00001000<=deadbeef#x";
      logic [1:0] obs, exp;
      obs_q.delete();
      exp_q = '{2'd2};
      for (int k = 0; k < s.len(); k++) begin
         drive_char(s[k], obs, exp);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL mem_record idx=%0d char=%c format_type=%0d expected=%0d", k, s[k], obs, exp);
         end
         if (obs != 2'd0) obs_q.push_back(obs);
      end
      total++;
      if (seq_sig(obs_q) != seq_sig(exp_q)) begin
         bad++;
         $display("FAIL mem_pulses pulses=%0d sig=%0d expected pulses=%0d sig=%0d",
                  obs_q.size(), seq_sig(obs_q), exp_q.size(), seq_sig(exp_q));
      end
   endtask

   task automatic test_malformed();
      string bad_recs[5];
      string s;
      logic [1:0] obs, exp;
      bad_recs[0] = "^12345@000030fc: $2 <= 89abcdef#";
      bad_recs[1] = "^1@0000300: $1 <= 00000000#";
      bad_recs[2] = "^1@000030fc: $1 < = 00000000#";
      bad_recs[3] = "^1@000030fc: $1 <= 89ABCDEF#";
      bad_recs[4] = "^@000030fc: $1 <= 00000000#^1@000030fc: $1 <= 000000001#";
      obs_q.delete();
      exp_q.delete();
      foreach (bad_recs[r]) begin
         s = bad_recs[r];
         for (int k = 0; k < s.len(); k++) begin
            drive_char(s[k], obs, exp);
            total++;
            if (obs !== exp) begin
               bad++;
               $display("FAIL malformed%0d idx=%0d char=%c format_type=%0d expected=%0d", r, k, s[k], obs, exp);
            end
            if (obs != 2'd0) obs_q.push_back(obs);
         end
      end
      total++;
      if (seq_sig(obs_q) != seq_sig(exp_q)) begin
         bad++;
         $display("FAIL malformed_pulses pulses=%0d expected pulses=%0d", obs_q.size(), exp_q.size());
      end
   endtask

   task automatic test_restart();
      string s = "^10@000030fc: $2 <= 89a^64@00003000:   $31   <=   00000001#";
      logic [1:0] obs, exp;
      obs_q.delete();
      exp_q = '{2'd1};
      for (int k = 0; k < s.len(); k++) begin
         drive_char(s[k], obs, exp);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL restart idx=%0d char=%c format_type=%0d expected=%0d", k, s[k], obs, exp);
         end
         if (obs != 2'd0) obs_q.push_back(obs);
      end
      total++;
      if (seq_sig(obs_q) != seq_sig(exp_q)) begin
         bad++;
         $display("FAIL restart_pulses pulses=%0d sig=%0d expected pulses=%0d sig=%0d",
                  obs_q.size(), seq_sig(obs_q), exp_q.size(), seq_sig(exp_q));
      end
   endtask

   task automatic test_back_to_back();
      string s = "^1024@000030fc: $2 <= 89abcdef#^7@0000abcd:*00001000<=deadbeef#^3@0000abcd: $9<=00000000#";
      logic [1:0] obs, exp;
      obs_q.delete();
      exp_q = '{2'd1, 2'd2, 2'd1};
      for (int k = 0; k < s.len(); k++) begin
         drive_char(s[k], obs, exp);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL back_to_back idx=%0d char=%c format_type=%0d expected=%0d", k, s[k], obs, exp);
         end
         if (obs != 2'd0) obs_q.push_back(obs);
      end
      total++;
      if (seq_sig(obs_q) != seq_sig(exp_q)) begin
         bad++;
         $display("FAIL b2b_pulses pulses=%0d sig=%0d expected pulses=%0d sig=%0d",
                  obs_q.size(), seq_sig(obs_q), exp_q.size(), seq_sig(exp_q));
      end
   endtask

   task automatic test_reset_mid_record();
      string segs[4];
      string s;
      logic [1:0] obs, exp;
      segs[0] = "^5@0000abcd: *00000010 <= 00000002#";
      segs[1] = "^1@0000";
      segs[2] = "30fc: $2 <= 89abcdef#";
      segs[3] = "^1@000030fc: $2 <= 89abcdef#";
      obs_q.delete();
      exp_q = '{2'd2, 2'd1};
      foreach (segs[g]) begin
         s = segs[g];
         for (int k = 0; k < s.len(); k++) begin
            drive_char(s[k], obs, exp);
            total++;
            if (obs !== exp) begin
               bad++;
               $display("FAIL reset_mid seg=%0d idx=%0d char=%c format_type=%0d expected=%0d", g, k, s[k], obs, exp);
            end
            if (obs != 2'd0) obs_q.push_back(obs);
         end
         if (g < 2) begin
            // Reset lands between clock edges; the output must clear at once.
            #2;
            reset = 1'b0;
            char  = 8'h00;
            #1;
            total++;
            if (format_type !== 2'd0) begin
               bad++;
               $display("FAIL async_reset seg=%0d format_type=%0d expected=0", g, format_type);
            end
            @(negedge clk);
            reset = 1'b1;
            mhave = 1'b0;
         end
      end
      total++;
      if (seq_sig(obs_q) != seq_sig(exp_q)) begin
         bad++;
         $display("FAIL reset_mid_pulses pulses=%0d sig=%0d expected pulses=%0d sig=%0d",
                  obs_q.size(), seq_sig(obs_q), exp_q.size(), seq_sig(exp_q));
      end
   endtask

   task automatic test_random();
      string junk = "^@:$*<=# 0123456789abcdefABxz";
      string s;
      string t;
      int r;
      int p;
      int hits = 0;
      logic [1:0] obs, exp;
      for (int rec = 0; rec < 60; rec++) begin
         r = int'($urandom_range(0, 9));
         s = {"^", rand_digits((r == 0) ? 5 : ((r == 1) ? 0 : int'($urandom_range(1, 4))), 1'b0, 1'b0), "@"};
         s = {s, rand_digits(rand_len8(), 1'b1, 1'b0), ":", spaces(int'($urandom_range(0, 2)))};
         if ($urandom_range(0, 1) == 0)
            s = {s, "$", rand_digits(int'($urandom_range(0, 5)), 1'b0, 1'b0)};
         else
            s = {s, "*", rand_digits(rand_len8(), 1'b1, 1'b0)};
         s = {s, spaces(int'($urandom_range(0, 2))), "<=", spaces(int'($urandom_range(0, 2)))};
         s = {s, rand_digits(rand_len8(), 1'b1, ($urandom_range(0, 7) == 0)), "#"};
         if ($urandom_range(0, 4) == 0) begin
            p = int'($urandom_range(0, s.len() - 1));
            t = "";
            for (int k = 0; k < s.len(); k++)
               t = $sformatf("%s%c", t, (k == p) ? junk[$urandom_range(0, junk.len() - 1)] : s[k]);
            s = t;
         end
         for (int j = int'($urandom_range(0, 2)); j > 0; j--)
            s = $sformatf("%s%c", s, junk[$urandom_range(0, junk.len() - 1)]);
         for (int k = 0; k < s.len(); k++) begin
            drive_char(s[k], obs, exp);
            total++;
            if (obs !== exp) begin
               bad++;
               $display("FAIL random rec=%0d idx=%0d char=%c format_type=%0d expected=%0d", rec, k, s[k], obs, exp);
            end
            if (exp != 2'd0) hits++;
         end
      end
      $display("random stream: %0d records recognised by the model", hits);
   endtask

   initial begin
      reset = 1'b0;
      char  = 8'h00;
      test_reset();
      test_reg_record();
      test_mem_record();
      test_malformed();
      test_restart();
      test_back_to_back();
      test_reset_mid_record();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
